// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl
//   Post-lock sequencer for the playfield. After a piece locks it scans the
//   board bottom-up for complete rows, collapses each one (rows above move
//   down one row per cycle), inserts net incoming garbage rows at the bottom
//   and hands the finished board back with a single write strobe.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   state_rst       synchronous game restart, same effect as rst (beats pause)
//   pause           freezes the FSM and every register while high
//   start           one-cycle request after a piece locks; only seen in IDLE
//   board_in        board snapshot, row r = bits [r*BLOCKS_ROW +: BLOCKS_ROW]
//   garbage_pending incoming garbage lines, sampled with start
//   garbage_hole    empty column of inserted garbage rows, sampled with start
//   board_out       registered result board
//   board_we        one-cycle strobe, board_out valid to write
//   busy            high in every state except IDLE
//   done            one-cycle pulse coincident with board_we
//   lines_cleared   rows cleared in the last pass, held until the next done
//   attack          lines sent to the opponent for the last pass
//   total_lines     saturating count of cleared rows since reset
//   topout          sticky, garbage pushed a non-empty row out of row 0

module line_clear_ctrl #(
   parameter int unsigned BLOCKS_ROW = 10,
   parameter int unsigned BLOCKS_COL = 20,
   parameter int unsigned BITS_Y_POS = 5
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             state_rst,
   input  logic                             pause,
   input  logic                             start,
   input  logic [BLOCKS_ROW*BLOCKS_COL-1:0] board_in,
   input  logic [2:0]                       garbage_pending,
   input  logic [3:0]                       garbage_hole,
   output logic [BLOCKS_ROW*BLOCKS_COL-1:0] board_out,
   output logic                             board_we,
   output logic                             busy,
   output logic                             done,
   output logic [2:0]                       lines_cleared,
   output logic [2:0]                       attack,
   output logic [7:0]                       total_lines,
   output logic                             topout
);

   localparam int unsigned BW = BLOCKS_ROW * BLOCKS_COL;
   localparam logic [BITS_Y_POS-1:0] ROW_BOTTOM = BITS_Y_POS'(BLOCKS_COL - 1);
   localparam logic [BITS_Y_POS-1:0] ROW_STEP   = BITS_Y_POS'(1);
   localparam logic [BLOCKS_ROW-1:0] CELL0      = BLOCKS_ROW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_SHIFT,
      S_GARB,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [BW-1:0]           wboard_q, wboard_d;
   logic [BITS_Y_POS-1:0]   row_q, row_d;
   logic [BITS_Y_POS-1:0]   ptr_q, ptr_d;
   logic [2:0]              cleared_q, cleared_d;
   logic [2:0]              gleft_q, gleft_d;
   logic [3:0]              hole_q, hole_d;
   logic [BW-1:0]           board_out_q, board_out_d;
   logic                    board_we_q, board_we_d;
   logic                    done_q, done_d;
   logic [2:0]              lines_q, lines_d;
   logic [2:0]              attack_q, attack_d;
   logic [7:0]              total_q, total_d;
   logic                    topout_q, topout_d;

   logic [BLOCKS_ROW-1:0]   scan_row;
   logic [BLOCKS_ROW-1:0]   garbage_row;
   logic [2:0]              net_garbage;
   logic [8:0]              total_sum;
   logic [2:0]              attack_val;

   // Row under test, selected with constant slices to keep the mux clean.
   always_comb begin
      scan_row = '0;
      for (int unsigned i = 0; i < BLOCKS_COL; i++) begin
         if (row_q == BITS_Y_POS'(i)) begin
            scan_row = wboard_q[i*BLOCKS_ROW +: BLOCKS_ROW];
         end
      end
   end

   assign garbage_row = ~(CELL0 << hole_q);
   assign net_garbage = (gleft_q > cleared_q) ? (gleft_q - cleared_q) : 3'd0;
   assign total_sum   = {1'b0, total_q} + {6'd0, cleared_q};

   always_comb begin
      unique case (cleared_q)
         3'd2:    attack_val = 3'd1;
         3'd3:    attack_val = 3'd2;
         3'd4:    attack_val = 3'd4;
         default: attack_val = 3'd0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wboard_d    = wboard_q;
      row_d       = row_q;
      ptr_d       = ptr_q;
      cleared_d   = cleared_q;
      gleft_d     = gleft_q;
      hole_d      = hole_q;
      board_out_d = board_out_q;
      board_we_d  = 1'b0;
      done_d      = 1'b0;
      lines_d     = lines_q;
      attack_d    = attack_q;
      total_d     = total_q;
      topout_d    = topout_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               wboard_d  = board_in;
               gleft_d   = garbage_pending;
               hole_d    = garbage_hole;
               row_d     = ROW_BOTTOM;
               cleared_d = '0;
               state_d   = S_SCAN;
            end
         end

         S_SCAN: begin
            if (&scan_row) begin
               ptr_d   = row_q;
               state_d = S_SHIFT;
            end else if (row_q == '0) begin
               // Clears cancel incoming garbage before any is inserted.
               gleft_d = net_garbage;
               state_d = (net_garbage != 3'd0) ? S_GARB : S_DONE;
            end else begin
               row_d = row_q - ROW_STEP;
            end
         end

         S_SHIFT: begin
            if (ptr_q != '0) begin
               for (int unsigned i = 1; i < BLOCKS_COL; i++) begin
                  if (ptr_q == BITS_Y_POS'(i)) begin
                     wboard_d[i*BLOCKS_ROW +: BLOCKS_ROW] =
                        wboard_q[(i-1)*BLOCKS_ROW +: BLOCKS_ROW];
                  end
               end
               ptr_d = ptr_q - ROW_STEP;
            end else begin
               // row_q is left alone so the row that slid into place is re-tested.
               wboard_d[BLOCKS_ROW-1:0] = '0;
               cleared_d                = cleared_q + 3'd1;
               state_d                  = S_SCAN;
            end
         end

         S_GARB: begin
            wboard_d = {garbage_row, wboard_q[BW-1:BLOCKS_ROW]};
            if (wboard_q[BLOCKS_ROW-1:0] != '0) begin
               topout_d = 1'b1;
            end
            gleft_d = gleft_q - 3'd1;
            if (gleft_q <= 3'd1) begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            board_out_d = wboard_q;
            board_we_d  = 1'b1;
            done_d      = 1'b1;
            lines_d     = cleared_q;
            attack_d    = attack_val;
            total_d     = total_sum[8] ? 8'hFF : total_sum[7:0];
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state_rst) begin
         state_q     <= S_IDLE;
         wboard_q    <= '0;
         row_q       <= '0;
         ptr_q       <= '0;
         cleared_q   <= '0;
         gleft_q     <= '0;
         hole_q      <= '0;
         board_out_q <= '0;
         board_we_q  <= 1'b0;
         done_q      <= 1'b0;
         lines_q     <= '0;
         attack_q    <= '0;
         total_q     <= '0;
         topout_q    <= 1'b0;
      end else if (!pause) begin
         state_q     <= state_d;
         wboard_q    <= wboard_d;
         row_q       <= row_d;
         ptr_q       <= ptr_d;
         cleared_q   <= cleared_d;
         gleft_q     <= gleft_d;
         hole_q      <= hole_d;
         board_out_q <= board_out_d;
         board_we_q  <= board_we_d;
         done_q      <= done_d;
         lines_q     <= lines_d;
         attack_q    <= attack_d;
         total_q     <= total_d;
         topout_q    <= topout_d;
      end
   end

   assign board_out     = board_out_q;
   assign board_we      = board_we_q;
   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign lines_cleared = lines_q;
   assign attack        = attack_q;
   assign total_lines   = total_q;
   assign topout        = topout_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
module tb_line_clear_ctrl;

   localparam int ROWW = 10;
   localparam int COLS = 20;
   localparam int BW   = ROWW * COLS;

   typedef logic [ROWW-1:0] row_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          state_rst = 1'b0;
   logic          pause = 1'b0;
   logic          start = 1'b0;
   logic [BW-1:0] board_in = '0;
   logic [2:0]    garbage_pending = '0;
   logic [3:0]    garbage_hole = '0;
   logic [BW-1:0] board_out;
   logic          board_we;
   logic          busy;
   logic          done;
   logic [2:0]    lines_cleared;
   logic [2:0]    attack;
   logic [7:0]    total_lines;
   logic          topout;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state carried across passes.
   int m_total  = 0;
   bit m_topout = 1'b0;

   line_clear_ctrl #(.BLOCKS_ROW(10), .BLOCKS_COL(20), .BITS_Y_POS(5)) dut (
      .clk(clk), .rst(rst), .state_rst(state_rst), .pause(pause), .start(start),
      .board_in(board_in), .garbage_pending(garbage_pending), .garbage_hole(garbage_hole),
      .board_out(board_out), .board_we(board_we), .busy(busy), .done(done),
      .lines_cleared(lines_cleared), .attack(attack), .total_lines(total_lines),
      .topout(topout)
   );

   always #5 clk = ~clk;

   function automatic int atk_of(input int c);
      if (c == 2) return 1;
      if (c == 3) return 2;
      if (c >= 4) return 4;
      return 0;
   endfunction

   // Pass result from the game rules: full rows vanish, the rest fall to the
   // bottom in order, then net garbage pushes the stack up from below.
   // Latency counts edges inclusively from the start-sampling edge to the
   // done edge; a full row cleared while sitting at index p costs p+2.
   task automatic model_pass(input logic [BW-1:0] b, input int g, input int h,
                             output logic [BW-1:0] res_v, output int cl, output int lat);
      row_t rows[COLS];
      row_t res[COLS];
      row_t kept[$];
      int   net;
      cl  = 0;
      lat = COLS + 2;
      for (int r = COLS - 1; r >= 0; r--) begin
         rows[r] = b[r*ROWW +: ROWW];
         if (rows[r] == 10'h3FF) begin
            lat += (r + cl) + 2;
            cl++;
         end else begin
            kept.push_back(rows[r]);
         end
      end
      for (int i = 0; i < COLS; i++) res[i] = '0;
      for (int i = 0; i < kept.size(); i++) res[COLS-1-i] = kept[i];
      net = (g > cl) ? g - cl : 0;
      for (int n = 0; n < net; n++) begin
         if (res[0] != '0) m_topout = 1'b1;
         for (int i = 0; i < COLS - 1; i++) res[i] = res[i+1];
         res[COLS-1] = 10'h3FF ^ (10'h001 << h);
         lat++;
      end
      for (int i = 0; i < COLS; i++) res_v[i*ROWW +: ROWW] = res[i];
      m_total = (m_total + cl > 255) ? 255 : m_total + cl;
   endtask

   task automatic gen_board(input int max_full, output logic [BW-1:0] b);
      int height;
      int fulls;
      row_t v;
      b      = '0;
      fulls  = 0;
      height = $urandom_range(0, COLS);
      for (int r = COLS - height; r < COLS; r++) begin
         if (fulls < max_full && $urandom_range(0, 3) == 0) begin
            v = 10'h3FF;
            fulls++;
         end else begin
            v = row_t'($urandom_range(0, 1022));
         end
         b[r*ROWW +: ROWW] = v;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_total  = 0;
      m_topout = 1'b0;
   endtask

   // Drives one pass and waits for done with a cycle budget. Optional pause
   // window and stray start pulse are placed by edge count after start.
   task automatic run_pass(input logic [BW-1:0] b, input int g, input int h,
                           input int pause_at, input int pause_len, input int poke_at,
                           output int lat, output bit to, output int busy_low);
      @(negedge clk);
      board_in        = b;
      garbage_pending = 3'(g);
      garbage_hole    = 4'(h);
      start           = 1'b1;
      @(posedge clk);
      #1;
      start           = 1'b0;
      board_in        = '1;
      garbage_pending = 3'd7;
      garbage_hole    = 4'd0;
      lat             = 1;
      busy_low        = 0;
      while (!done && lat < 600) begin
         if (lat == pause_at) pause = 1'b1;
         if (lat == pause_at + pause_len) pause = 1'b0;
         start = (lat == poke_at);
         if (!busy) busy_low++;
         @(posedge clk);
         #1;
         lat++;
      end
      start = 1'b0;
      pause = 1'b0;
      to    = !done;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      vectors++;
      if (board_out !== '0 || board_we !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_board: board_out=%h we=%b done=%b, want 0", board_out, board_we, done);
         miscompares++;
      end
      vectors++;
      if (busy !== 1'b0 || lines_cleared !== 3'd0 || attack !== 3'd0) begin
         $display("FAIL reset_status: busy=%b lines=%0d attack=%0d, want 0", busy, lines_cleared, attack);
         miscompares++;
      end
      vectors++;
      if (total_lines !== 8'd0 || topout !== 1'b0) begin
         $display("FAIL reset_counters: total=%0d topout=%b, want 0", total_lines, topout);
         miscompares++;
      end
   endtask

   task automatic test_empty();
      logic [BW-1:0] exp_b;
      int cl, mlat, lat, bl;
      bit to;
      model_pass('0, 0, 0, exp_b, cl, mlat);
      run_pass('0, 0, 0, -1, 0, -1, lat, to, bl);
      vectors++;
      if (to || lat != 22 || lat != mlat) begin
         $display("FAIL empty_latency: got %0d (timeout=%b), want 22", lat, to);
         miscompares++;
      end
      vectors++;
      if (board_we !== 1'b1 || board_out !== exp_b || lines_cleared !== 3'd0 || attack !== 3'd0) begin
         $display("FAIL empty_result: we=%b out=%h lines=%0d attack=%0d, want we=1 out=0 0 0",
                  board_we, board_out, lines_cleared, attack);
         miscompares++;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (done !== 1'b0 || board_we !== 1'b0) begin
         $display("FAIL empty_pulse: done=%b we=%b one cycle later, want 0 0", done, board_we);
         miscompares++;
      end
   endtask

   task automatic test_single_clear();
      logic [BW-1:0] b, exp_b;
      int lat, bl;
      bit to;
      b = '0;
      b[19*ROWW +: ROWW] = 10'h3FF;
      b[18*ROWW +: ROWW] = 10'h001;
      exp_b = '0;
      exp_b[19*ROWW +: ROWW] = 10'h001;
      m_total += 1;
      run_pass(b, 0, 0, -1, 0, -1, lat, to, bl);
      vectors++;
      if (to || lat != 43) begin
         $display("FAIL single_latency: got %0d (timeout=%b), want 43", lat, to);
         miscompares++;
      end
      vectors++;
      if (board_out !== exp_b) begin
         $display("FAIL single_board: got %h want %h", board_out, exp_b);
         miscompares++;
      end
      vectors++;
      if (lines_cleared !== 3'd1 || total_lines !== 8'(m_total) || bl != 0) begin
         $display("FAIL single_counts: lines=%0d total=%0d busy_low=%0d, want 1 %0d 0",
                  lines_cleared, total_lines, bl, m_total);
         miscompares++;
      end
   endtask

   task automatic test_tetris();
      logic [BW-1:0] b;
      int lat, bl;
      bit to;
      do_reset();
      b = '0;
      for (int r = 16; r < 20; r++) b[r*ROWW +: ROWW] = 10'h3FF;
      for (int pass = 1; pass <= 2; pass++) begin
         run_pass(b, 0, 0, -1, 0, -1, lat, to, bl);
         vectors++;
         if (to || lines_cleared !== 3'd4 || attack !== 3'd4 || board_out !== '0) begin
            $display("FAIL tetris_result: pass %0d lines=%0d attack=%0d out=%h, want 4 4 0",
                     pass, lines_cleared, attack, board_out);
            miscompares++;
         end
         vectors++;
         if (total_lines !== 8'(4 * pass)) begin
            $display("FAIL tetris_total: pass %0d got %0d want %0d", pass, total_lines, 4 * pass);
            miscompares++;
         end
      end
      m_total = 8;
   endtask

   task automatic test_attack_table();
      logic [BW-1:0] b, exp_b;
      int cl, mlat, lat, bl;
      bit to;
      for (int k = 0; k <= 4; k++) begin
         gen_board(0, b);
         for (int r = COLS - k; r < COLS; r++) b[r*ROWW +: ROWW] = 10'h3FF;
         model_pass(b, 0, 0, exp_b, cl, mlat);
         run_pass(b, 0, 0, -1, 0, -1, lat, to, bl);
         vectors++;
         if (to || attack !== 3'(atk_of(k)) || lines_cleared !== 3'(k) || lat != mlat) begin
            $display("FAIL attack_k%0d: attack=%0d lines=%0d lat=%0d, want %0d %0d %0d",
                     k, attack, lines_cleared, lat, atk_of(k), k, mlat);
            miscompares++;
         end
      end
   endtask

   task automatic test_garbage();
      logic [BW-1:0] exp_b;
      int cl, mlat, lat, bl;
      bit to;
      exp_b = '0;
      exp_b[18*ROWW +: ROWW] = 10'h3F7;
      exp_b[19*ROWW +: ROWW] = 10'h3F7;
      model_pass('0, 2, 3, exp_b, cl, mlat);
      run_pass('0, 2, 3, -1, 0, -1, lat, to, bl);
      vectors++;
      if (to || lat != 24) begin
         $display("FAIL garbage_latency: got %0d (timeout=%b), want 24", lat, to);
         miscompares++;
      end
      vectors++;
      if (board_out[18*ROWW +: ROWW] !== 10'h3F7 || board_out[19*ROWW +: ROWW] !== 10'h3F7 ||
          board_out !== exp_b || topout !== 1'b0) begin
         $display("FAIL garbage_board: got %h topout=%b, want %h topout=0", board_out, topout, exp_b);
         miscompares++;
      end
   endtask

   task automatic test_topout();
      logic [BW-1:0] b, exp_b;
      int cl, mlat, lat, bl;
      bit to;
      b = '0;
      b[0 +: ROWW] = 10'h001;
      model_pass(b, 1, 5, exp_b, cl, mlat);
      run_pass(b, 1, 5, -1, 0, -1, lat, to, bl);
      vectors++;
      if (to || topout !== 1'b1 || board_out !== exp_b) begin
         $display("FAIL topout_set: topout=%b out=%h, want 1 %h", topout, board_out, exp_b);
         miscompares++;
      end
      model_pass('0, 0, 0, exp_b, cl, mlat);
      run_pass('0, 0, 0, -1, 0, -1, lat, to, bl);
      vectors++;
      if (to || topout !== 1'b1) begin
         $display("FAIL topout_sticky: topout=%b, want 1", topout);
         miscompares++;
      end
      @(negedge clk);
      state_rst = 1'b1;
      @(negedge clk);
      state_rst = 1'b0;
      m_total  = 0;
      m_topout = 1'b0;
      vectors++;
      if (topout !== 1'b0 || board_out !== '0 || total_lines !== 8'd0 ||
          lines_cleared !== 3'd0 || attack !== 3'd0 || busy !== 1'b0) begin
         $display("FAIL topout_state_rst: topout=%b out=%h total=%0d lines=%0d attack=%0d busy=%b, want all 0",
                  topout, board_out, total_lines, lines_cleared, attack, busy);
         miscompares++;
      end
   endtask

   task automatic test_pause();
      logic [BW-1:0] b, exp_b;
      int cl, mlat, lat, bl;
      bit to;
      b = '0;
      b[19*ROWW +: ROWW] = 10'h3FF;
      b[18*ROWW +: ROWW] = 10'h155;
      b[17*ROWW +: ROWW] = 10'h0F0;
      model_pass(b, 0, 0, exp_b, cl, mlat);
      // Edge 2 enters SHIFT; pausing after edge 5 lands mid-shift.
      run_pass(b, 0, 0, 5, 5, -1, lat, to, bl);
      vectors++;
      if (to || lat != mlat + 5 || board_out !== exp_b) begin
         $display("FAIL pause_shift: lat=%0d out=%h, want %0d %h", lat, board_out, mlat + 5, exp_b);
         miscompares++;
      end
      // start during pause in IDLE is lost
      @(negedge clk);
      pause = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      pause = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL pause_start_lost: busy=%b done=%b, want 0 0", busy, done);
         miscompares++;
      end
   endtask

   task automatic test_busy_start();
      logic [BW-1:0] b, exp_b;
      int cl, mlat, lat, bl;
      bit to;
      gen_board(2, b);
      model_pass(b, 3, 7, exp_b, cl, mlat);
      run_pass(b, 3, 7, -1, 0, 10, lat, to, bl);
      vectors++;
      if (to || lat != mlat || board_out !== exp_b || bl != 0) begin
         $display("FAIL busy_start_ignored: lat=%0d out=%h busy_low=%0d, want %0d %h 0",
                  lat, board_out, bl, mlat, exp_b);
         miscompares++;
      end
   endtask

   task automatic test_state_rst_abort();
      int we_seen;
      @(negedge clk);
      board_in = '0;
      garbage_pending = 3'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      state_rst = 1'b1;
      @(negedge clk);
      state_rst = 1'b0;
      m_total  = 0;
      m_topout = 1'b0;
      vectors++;
      if (busy !== 1'b0) begin
         $display("FAIL abort_idle: busy=%b, want 0", busy);
         miscompares++;
      end
      we_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (board_we || done) we_seen++;
      end
      vectors++;
      if (we_seen != 0 || board_out !== '0 || total_lines !== 8'd0) begin
         $display("FAIL abort_no_write: we_cycles=%0d out=%h total=%0d, want 0 0 0",
                  we_seen, board_out, total_lines);
         miscompares++;
      end
   endtask

   task automatic test_random();
      logic [BW-1:0] b, exp_b;
      int cl, mlat, lat, bl, g, h;
      bit to;
      for (int n = 0; n < 30; n++) begin
         gen_board(4, b);
         g = $urandom_range(0, 7);
         h = $urandom_range(0, ROWW - 1);
         model_pass(b, g, h, exp_b, cl, mlat);
         run_pass(b, g, h, -1, 0, -1, lat, to, bl);
         vectors++;
         if (to || lat != mlat || bl != 0) begin
            $display("FAIL rand%0d_timing: lat=%0d timeout=%b busy_low=%0d, want %0d 0 0",
                     n, lat, to, bl, mlat);
            miscompares++;
         end
         vectors++;
         if (board_out !== exp_b || board_we !== 1'b1) begin
            $display("FAIL rand%0d_board: got %h we=%b want %h", n, board_out, board_we, exp_b);
            miscompares++;
         end
         vectors++;
         if (lines_cleared !== 3'(cl) || attack !== 3'(atk_of(cl)) ||
             total_lines !== 8'(m_total) || topout !== m_topout) begin
            $display("FAIL rand%0d_status: lines=%0d attack=%0d total=%0d topout=%b, want %0d %0d %0d %b",
                     n, lines_cleared, attack, total_lines, topout, cl, atk_of(cl), m_total, m_topout);
            miscompares++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_single_clear();
      test_tetris();
      test_attack_table();
      test_garbage();
      test_topout();
      test_pause();
      test_busy_start();
      test_state_rst_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/line_clear_ctrl.md
Name: line_clear_ctrl

Overview:
- Post-lock sequencer for the playfield.
- After a piece locks, it scans the board bottom-up for complete rows and collapses each one, shifting the rows above it down one row per cycle.
- It then inserts any net incoming garbage rows at the bottom and writes the finished board back in a single write strobe.
- It sits between the piece-lock logic, the board register and the versus (attack/garbage) logic.

Parameters:
BLOCKS_ROW, 10, cells per row (row width)
BLOCKS_COL, 20, number of rows; row 0 = top, row BLOCKS_COL-1 = bottom
BITS_Y_POS, 5, width of row indices

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
state_rst  in  1  synchronous game restart; same effect as rst
pause  in  1  freezes FSM and all registers while high
start  in  1  one-cycle request after a piece locks; ignored unless IDLE
board_in  in  BLOCKS_ROW*BLOCKS_COL  board snapshot; row r = bits [r*BLOCKS_ROW +: BLOCKS_ROW]
garbage_pending  in  3  incoming garbage lines; sampled with start
garbage_hole  in  4  empty column of inserted garbage rows; sampled with start; valid range 0..BLOCKS_ROW-1
board_out  out  BLOCKS_ROW*BLOCKS_COL  registered result board
board_we  out  1  one-cycle strobe: board_out is valid to write
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, coincident with board_we
lines_cleared  out  3  rows cleared in the last pass (0..4); held until the next done
attack  out  3  lines sent to the opponent for the last pass; held until the next done
total_lines  out  8  saturating count of cleared rows since reset
topout  out  1  sticky; set when garbage pushes a non-empty row out of row 0

Behaviour:
- Reset (rst or state_rst): state = IDLE, and all outputs and internal registers = 0. state_rst overrides pause. Reset mid-pass aborts the pass with no board_we.
- pause high: no state or register change; any start pulse during pause is lost.
- Internal registers: wboard (working copy), row, ptr, cleared (3b), gleft (3b), hole.
- IDLE: on start, latch wboard = board_in, gleft = garbage_pending, hole = garbage_hole, row = BLOCKS_COL-1, cleared = 0, then go to SCAN.
- SCAN: test whether wboard row `row` is all ones.
  - If full: ptr = row, go to SHIFT.
  - Else if row == 0: compute gleft = (gleft > cleared) ? gleft - cleared : 0, then go to GARB if the result is nonzero, else to DONE.
  - Else: row = row - 1.
- SHIFT, one row per cycle:
  - While ptr != 0: wboard row ptr = row ptr-1, then ptr = ptr-1.
  - When ptr == 0: row 0 = 0, cleared = cleared + 1, then return to SCAN with `row` unchanged, so the row that moved into that position is re-tested.
- GARB, one line per cycle:
  - Each row i takes row i+1 (for i = 0..BLOCKS_COL-2); the old row 0 is discarded.
  - If the discarded row 0 was nonzero, set topout.
  - Bottom row = all ones except bit `hole`.
  - gleft = gleft - 1; when it reaches 0, go to DONE.
- DONE, one cycle: board_out = wboard, board_we = 1, done = 1, lines_cleared = cleared, attack as below, total_lines += cleared (saturating at 255), then go to IDLE.
- attack mapping from cleared: 0 or 1 → 0; 2 → 1; 3 → 2; 4 → 4.
- Latency, counted in edges from the edge that samples start to the edge that raises done:
  - Base: BLOCKS_COL + 2 (22 with defaults).
  - Each cleared row at index r adds r + 2.
  - Each inserted garbage line adds 1.
- Garbage cancellation: clears are subtracted from gleft before insertion. No garbage is ever inserted when cleared ≥ garbage_pending.
- cleared cannot exceed 4 for legal boards. The counter is not required to handle more than 7.

Test Plan:
1. Empty board, start, garbage_pending = 0 → done and board_we exactly 22 edges later; board_out = 0; lines_cleared = 0; attack = 0.
2. Only row 19 full, row 18 = 0x001 → done after 22 + 21 = 43 edges; row 19 = 0x001; rows 0..18 = 0; lines_cleared = 1; total_lines = 1.
3. Rows 16..19 full (tetris) → lines_cleared = 4, attack = 4, board_out = 0; a second identical pass → total_lines = 8.
4. Empty board, garbage_pending = 2, hole = 3 → rows 18 and 19 = 0x3F7; done after 24 edges; topout = 0.
5. Row 0 nonzero, garbage_pending = 1 → topout = 1 and stays set; state_rst clears it and zeroes all outputs.
6. Pause held for 5 cycles mid-SHIFT → done is delayed by exactly 5 edges with an identical board_out. A start pulse while busy is ignored; state_rst mid-SCAN → IDLE with no board_we.
